// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: rotating-priority grant of the shared bus among
// N_MASTERS active-low Req/Gnt pairs. Watches Frame/Irdy for idle and end of
// transaction, parks the bus on PARK_MASTER when nobody asks, and takes a
// grant back (with a one-cycle Timeout pulse) if the bus stays idle too long.
module pci_bus_arbiter #(
    parameter int N_MASTERS    = 4,
    parameter int IDLE_TIMEOUT = 16,
    parameter int PARK_MASTER  = 0
) (
    input  logic                 Clock,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] Req,
    input  logic                 Frame,
    input  logic                 Irdy,
    output logic [N_MASTERS-1:0] Gnt,
    output logic [2:0]           BusOwner,
    output logic                 BusIdle,
    output logic                 Timeout
);

    localparam int IW = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1;
    localparam int TW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [TW-1:0]        TIMER_MAX = TW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0]        PARK_IDX  = IW'(PARK_MASTER);
    localparam logic [IW-1:0]        LAST_IDX  = IW'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] ALL_HIGH  = '1;

    // GAP: one dead cycle with every grant high, used between different owners.
    // PARK: nobody asked, bus handed to PARK_MASTER.
    // GRANT: owner may start; idle time is being counted.
    // BUSY: a transaction is on the bus.
    typedef enum logic [1:0] {
        ST_GAP,
        ST_PARK,
        ST_GRANT,
        ST_BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   timeout_q, timeout_d;

    logic [N_MASTERS-1:0]   req_act;
    logic [2*N_MASTERS-1:0] req_dbl;
    logic [N_MASTERS-1:0]   rotated;
    logic [IW:0]            shift_amt;
    logic [IW-1:0]          offset;
    logic [IW+1:0]          win_sum;
    logic [IW-1:0]          winner;

    logic [N_MASTERS-1:0]   owner_mask;
    logic                   any_req;
    logic                   owner_req;
    logic                   others_req;
    logic                   owner_gnt;
    logic                   keep_gnt;

    assign BusIdle  = Frame & Irdy;
    assign Gnt      = gnt_q;
    assign BusOwner = 3'(owner_q);
    assign Timeout  = timeout_q;

    // Round-robin winner: first active request after the current owner, owner last.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_act   = ~Req;
        req_dbl   = {req_act, req_act};
        shift_amt = {1'b0, owner_q} + (IW + 1)'(1);
        rotated   = N_MASTERS'(req_dbl >> shift_amt);
        offset    = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = IW'(k);
            end
        end
        win_sum = (IW + 2)'(shift_amt) + (IW + 2)'(offset);
        if (win_sum >= (IW + 2)'(N_MASTERS)) begin
            win_sum = win_sum - (IW + 2)'(N_MASTERS);
        end
        winner = win_sum[IW-1:0];
    end

    // Request/grant summaries relative to the current owner.
    always_comb begin
        owner_mask = N_MASTERS'(1) << owner_q;
        any_req    = |req_act;
        owner_req  = |(req_act & owner_mask);
        others_req = |(req_act & ~owner_mask);
        owner_gnt  = |(~gnt_q & owner_mask);
        keep_gnt   = owner_gnt & owner_req & ~others_req;
    end

    // Next-state, next-grant, owner, idle timer and timeout pulse.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_GAP: begin
                timer_d = '0;
                if (any_req) begin
                    state_d = ST_GRANT;
                    owner_d = winner;
                    gnt_d   = ~(N_MASTERS'(1) << winner);
                end else begin
                    state_d = ST_PARK;
                    owner_d = PARK_IDX;
                    gnt_d   = ~(N_MASTERS'(1) << PARK_IDX);
                end
            end

            ST_PARK: begin
                timer_d = '0;
                if (!BusIdle) begin
                    // Parked master started without asking.
                    state_d = ST_BUSY;
                end else if (any_req && winner == PARK_IDX) begin
                    // Park master is the only requester: keep its grant, no gap.
                    state_d = ST_GRANT;
                end else if (any_req) begin
                    state_d = ST_GAP;
                    gnt_d   = ALL_HIGH;
                end
            end

            ST_GRANT: begin
                if (!Frame) begin
                    state_d = ST_BUSY;
                    timer_d = '0;
                end else if (!owner_req) begin
                    state_d = ST_GAP;
                    gnt_d   = ALL_HIGH;
                    timer_d = '0;
                end else if (timer_q == TIMER_MAX) begin
                    // Unused grant: revoke it. Owner is kept so it ranks last next time.
                    state_d   = ST_GAP;
                    gnt_d     = ALL_HIGH;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else if (BusIdle) begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_BUSY: begin
                timer_d = '0;
                if (BusIdle) begin
                    state_d = keep_gnt ? ST_GRANT : ST_GAP;
                    gnt_d   = keep_gnt ? gnt_q : ALL_HIGH;
                end else if (!keep_gnt) begin
                    // Someone else is waiting: release now, once released stay released.
                    gnt_d = ALL_HIGH;
                end
            end

            default: begin
                state_d = ST_GAP;
                gnt_d   = ALL_HIGH;
                timer_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset releases every grant immediately.
    always_ff @(posedge Clock or posedge RST) begin
        if (RST) begin
            state_q   <= ST_GAP;
            gnt_q     <= ALL_HIGH;
            owner_q   <= LAST_IDX;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (4 masters, timeout 16, park on 0).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pci_bus_arbiter;

    logic       Clock;
    logic       RST;
    logic [3:0] Req;
    logic       Frame;
    logic       Irdy;
    logic [3:0] Gnt;
    logic [2:0] BusOwner;
    logic       BusIdle;
    logic       Timeout;

    int n_compared   = 0;
    int n_mismatched = 0;

    pci_bus_arbiter #(
        .N_MASTERS   (4),
        .IDLE_TIMEOUT(16),
        .PARK_MASTER (0)
    ) dut (
        .Clock   (Clock),
        .RST     (RST),
        .Req     (Req),
        .Frame   (Frame),
        .Irdy    (Irdy),
        .Gnt     (Gnt),
        .BusOwner(BusOwner),
        .BusIdle (BusIdle),
        .Timeout (Timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_gnt(input string tag, input logic [3:0] exp);
        check(tag, 8'(Gnt), 8'(exp));
    endtask

    task automatic check_owner(input string tag, input logic [2:0] exp);
        check(tag, 8'(BusOwner), 8'(exp));
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, 8'(obs), 8'(exp));
    endtask

    // Advance one edge and check that never more than one grant is low.
    task automatic step();
        @(posedge Clock);
        #1;
        check_bit("gnt_one_hot", ($countones(~Gnt) <= 1), 1'b1);
    endtask

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;

    initial begin
        RST   = 1'b1;
        Req   = 4'b1111;
        Frame = 1'b1;
        Irdy  = 1'b1;
        #1;
        // Reset values
        check_gnt("rst_gnt", 4'b1111);
        check_owner("rst_owner", 3'd3);
        check_bit("rst_timeout", Timeout, 1'b0);
        check_bit("rst_busidle", BusIdle, 1'b1);

        // BusIdle is purely combinational
        Frame = 1'b0;
        #1;
        check_bit("busidle_frame", BusIdle, 1'b0);
        Frame = 1'b1;
        Irdy  = 1'b0;
        #1;
        check_bit("busidle_irdy", BusIdle, 1'b0);
        Irdy = 1'b1;

        step();
        RST = 1'b0;
        // First cycle after release is GAP
        check_gnt("gap_after_rst", 4'b1111);
        step();
        check_gnt("park_gnt", 4'b1110);
        check_owner("park_owner", 3'd0);
        step();
        step();
        step();
        check_gnt("park_hold", 4'b1110);
        check_bit("park_timeout", Timeout, 1'b0);

        // Master 1 requests while parked: gap then grant
        Req = 4'b1101;
        step();
        check_gnt("m1_gap", 4'b1111);
        step();
        check_gnt("m1_grant", 4'b1101);
        check_owner("m1_owner", 3'd1);
        step();
        check_gnt("m1_wait", 4'b1101);
        Frame = 1'b0;
        Irdy  = 1'b0;
        step();
        check_gnt("m1_busy1", 4'b1101);
        step();
        step();
        check_gnt("m1_busy3", 4'b1101);
        Frame = 1'b1;
        Irdy  = 1'b1;
        step();
        // Sole requester: straight back to GRANT, no gap
        check_gnt("m1_b2b", 4'b1101);
        check_owner("m1_b2b_owner", 3'd1);
        Req = 4'b1111;
        step();
        check_gnt("m1_drop_gap", 4'b1111);
        step();
        check_gnt("m1_repark", 4'b1110);

        // Park master sole requester: PARK -> GRANT without gap
        Req = 4'b1110;
        step();
        check_gnt("park_grant", 4'b1110);
        Req = 4'b1111;
        step();
        // Only GRANT reacts to the owner dropping its request
        check_gnt("park_grant_drop", 4'b1111);
        step();
        check_gnt("park_again", 4'b1110);

        // Round-robin with everyone requesting, from a fresh reset
        RST = 1'b1;
        Req = 4'b0000;
        #1;
        check_owner("rr_rst_owner", 3'd3);
        step();
        RST = 1'b0;
        check_gnt("rr_first_gap", 4'b1111);
        for (int i = 0; i < 5; i++) begin
            exp_g = ~(4'b0001 << order[i]);
            step();
            check_gnt("rr_grant", exp_g);
            check_owner("rr_owner", 3'(order[i]));
            Frame = 1'b0;
            Irdy  = 1'b0;
            step();
            check_gnt("rr_busy", exp_g);
            Frame = 1'b1;
            Irdy  = 1'b1;
            step();
            check_gnt("rr_gap", 4'b1111);
        end
        Req = 4'b1111;
        step();
        check_gnt("rr_park", 4'b1110);

        // Unused grant timeout
        Req = 4'b1011;
        step();
        check_gnt("to_gap", 4'b1111);
        step();
        check_gnt("to_grant_c1", 4'b1011);
        check_owner("to_owner", 3'd2);
        for (int c = 2; c <= 16; c++) begin
            step();
            check_gnt("to_grant_hold", 4'b1011);
            check_bit("to_no_pulse", Timeout, 1'b0);
        end
        step();
        check_gnt("to_revoked", 4'b1111);
        check_bit("to_pulse", Timeout, 1'b1);
        step();
        check_bit("to_pulse_end", Timeout, 1'b0);
        check_gnt("to_regrant", 4'b1011);
        check_owner("to_regrant_owner", 3'd2);
        Req = 4'b1111;
        step();
        step();
        check_gnt("to_park", 4'b1110);

        // Master 0 transaction interrupted by a request from master 3
        Req   = 4'b1110;
        Frame = 1'b0;
        Irdy  = 1'b0;
        step();
        check_gnt("pre_busy", 4'b1110);
        Req = 4'b0110;
        step();
        check_gnt("pre_release", 4'b1111);
        step();
        check_gnt("pre_stay_high", 4'b1111);
        Frame = 1'b1;
        Irdy  = 1'b1;
        step();
        check_gnt("pre_gap", 4'b1111);
        step();
        check_gnt("pre_m3_gnt", 4'b0111);
        check_owner("pre_m3_owner", 3'd3);

        // Owner drops while another asks: gap first
        Req = 4'b1101;
        step();
        check_gnt("sw_gap", 4'b1111);
        step();
        check_gnt("sw_m1_gnt", 4'b1101);
        Frame = 1'b0;
        Irdy  = 1'b0;
        step();
        step();
        check_gnt("sw_m1_busy", 4'b1101);

        // Asynchronous reset mid-transaction
        RST = 1'b1;
        #1;
        check_gnt("arst_gnt", 4'b1111);
        check_owner("arst_owner", 3'd3);
        step();
        check_gnt("arst_hold", 4'b1111);
        RST   = 1'b0;
        Frame = 1'b1;
        Irdy  = 1'b1;
        check_gnt("arst_gap", 4'b1111);
        step();
        check_gnt("arst_regrant", 4'b1101);
        check_owner("arst_regrant_owner", 3'd1);

        // Owner drop and new request on the same edge
        Req = 4'b1011;
        step();
        check_gnt("simul_gap", 4'b1111);
        step();
        check_gnt("simul_m2", 4'b1011);
        check_owner("simul_m2_owner", 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
